// File: rtl/grid_port_arbiter.sv
// Round-robin arbiter sharing the single-port grid RAM between NREQ requesters.
// Define GRID_CLAIM_EN to build the atomic claim (test-and-set) path.
module grid_port_arbiter #(
    parameter int NREQ = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter logic [DATA_W-1:0] EMPTY = {DATA_W{1'b1}}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [2*NREQ-1:0]        op,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    input  logic [NREQ*DATA_W-1:0]   wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic                     claim_ok,
    output logic                     busy,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] WR   = 3'd1;
    localparam logic [2:0] RD   = 3'd2;
    localparam logic [2:0] RESP = 3'd3;
`ifdef GRID_CLAIM_EN
    localparam logic [2:0] CHK  = 3'd4;
    localparam logic [2:0] CWR  = 3'd5;
`endif

    logic [2:0]        state, state_n;
    logic [PTR_W-1:0]  ptr, cur, win, idx;
    logic              found;
    logic [1:0]        w_op;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_wr;
`ifdef GRID_CLAIM_EN
    logic              claim;
    logic              w_claim;
`endif

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        win = '0;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end

    always_comb begin
        w_op = '0;
        w_addr = '0;
        w_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win == PTR_W'(k)) begin
                w_op = op[2*k +: 2];
                w_addr = addr[k*ADDR_W +: ADDR_W];
                w_data = wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    assign w_wr = (w_op == 2'b01);
`ifdef GRID_CLAIM_EN
    assign w_claim = (w_op == 2'b10);
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (found) state_n = w_wr ? WR : RD;
            WR:   state_n = IDLE;
`ifdef GRID_CLAIM_EN
            RD:   state_n = claim ? CHK : RESP;
            CHK:  state_n = (mem_rdata == EMPTY) ? CWR : IDLE;
            CWR:  state_n = IDLE;
`else
            RD:   state_n = RESP;
`endif
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            cur       <= '0;
            gnt       <= '0;
            rvalid    <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef GRID_CLAIM_EN
            claim     <= 1'b0;
            claim_ok  <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            busy      <= (state_n != IDLE);
            gnt       <= '0;
            rvalid    <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            case (state)
                IDLE: if (found) begin
                    gnt[win]  <= 1'b1;
                    cur       <= win;
                    ptr       <= (win == PTR_W'(NREQ - 1)) ? '0 : win + 1'b1;
                    mem_addr  <= w_addr;
                    mem_wdata <= w_data;
                    mem_write <= w_wr;
                    mem_read  <= !w_wr;
`ifdef GRID_CLAIM_EN
                    claim     <= w_claim;
`endif
                end
                RESP: begin
                    rdata       <= mem_rdata;
                    rvalid[cur] <= 1'b1;
`ifdef GRID_CLAIM_EN
                    claim_ok    <= 1'b0;
`endif
                end
`ifdef GRID_CLAIM_EN
                // Address and data are still held from the grant edge.
                CHK: begin
                    rdata       <= mem_rdata;
                    rvalid[cur] <= 1'b1;
                    claim_ok    <= (mem_rdata == EMPTY);
                    mem_write   <= (mem_rdata == EMPTY);
                end
`endif
                default: ;
            endcase
        end
    end

`ifndef GRID_CLAIM_EN
    assign claim_ok = 1'b0;
`endif

endmodule

// File: tb/tb_grid_port_arbiter.sv
// Scoreboard bench for grid_port_arbiter with a 1-cycle registered RAM model.
module tb_grid_port_arbiter;

    localparam int NREQ = 4;
    localparam int AW = 12;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [2*NREQ-1:0] op = '0;
    logic [NREQ*AW-1:0] addr = '0;
    logic [NREQ*DW-1:0] wdata = '0;
    logic [NREQ-1:0]   gnt, rvalid;
    logic [DW-1:0]     rdata, mem_wdata, mem_rdata;
    logic              claim_ok, busy, mem_read, mem_write;
    logic [AW-1:0]     mem_addr;

    grid_port_arbiter dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .claim_ok(claim_ok), .busy(busy), .mem_read(mem_read),
        .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    initial mem_rdata = '0;
    always @(posedge clk) begin
        if (mem_write) ram[mem_addr] = mem_wdata;
        if (mem_read) mem_rdata <= ram[mem_addr];
    end

    typedef struct packed {
        logic [7:0]    idx;
        logic          ok;
        logic [DW-1:0] data;
    } sb_t;

    sb_t sb[$];
    sb_t e_cur;
    int n_run = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && |rvalid) begin
            if (sb.size() == 0) begin
                chk("rv_unexp", 64'(rvalid), 64'd0);
            end else begin
                e_cur = sb.pop_front();
                chk("rv_who", 64'(rvalid), 64'(4'b1 << e_cur.idx));
                chk("rdata", 64'(rdata), 64'(e_cur.data));
                chk("claim_ok", 64'(claim_ok), 64'(e_cur.ok));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        req = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic drive(input int i, input logic [1:0] o,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i] = 1'b1;
        op[2*i +: 2] = o;
        addr[i*AW +: AW] = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_gnt(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (gnt == '0 && cnt < 30);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("idle", 64'(busy), 64'd0);
    endtask

    // One command from one requester with cycle-exact strobe checks.
    task automatic do_cmd(input int i, input logic [1:0] o,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] exp_rd, input logic exp_ok);
        int cnt;
        logic is_wr;
        is_wr = (o == 2'b01);
        @(posedge clk); #1;
        drive(i, o, a, d);
        if (!is_wr) sb.push_back('{idx: 8'(i), ok: exp_ok, data: exp_rd});
        wait_gnt(cnt);
        chk("gnt", 64'(gnt), 64'(4'b1 << i));
        chk("gnt_lat", 64'(cnt), 64'd2);
        chk("strobe_wr", 64'(mem_write), 64'(is_wr));
        chk("strobe_rd", 64'(mem_read), 64'(!is_wr));
        chk("mem_addr", 64'(mem_addr), 64'(a));
        @(posedge clk); #1;
        req[i] = 1'b0;
        @(negedge clk);
        chk("rv_early", 64'(rvalid), 64'd0);
        @(negedge clk);
        if (is_wr) begin
            chk("wr_norv", 64'(rvalid), 64'd0);
        end else begin
            chk("rv_t3", 64'(rvalid), 64'(4'b1 << i));
            chk("claim_wr", 64'(mem_write), 64'(exp_ok));
            if (exp_ok) chk("claim_wdata", 64'(mem_wdata), 64'(d));
        end
        wait_idle();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", 64'(sb.size()), 64'd0);
    endtask

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int k = 0; k < NREQ; k++) if (v[k]) r = k;
        return r;
    endfunction

    initial begin
        int cnt;
        int order [5];
        int exp_order [5];
        int n;
        exp_order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < (1 << AW); k++) ram[k] = DW'(k);
        ram[7] = 32'd5;
        ram[14] = 32'hFFFF_FFFF;
        for (int k = 0; k < NREQ; k++) ram[100 + k] = 32'hA0 + DW'(k);

        do_reset();
        @(negedge clk);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_rvalid", 64'(rvalid), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_claim", 64'(claim_ok), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_strobes", 64'({mem_read, mem_write}), 64'd0);
        chk("rst_maddr", 64'(mem_addr), 64'd0);
        chk("rst_mwdata", 64'(mem_wdata), 64'd0);

        do_cmd(2, 2'b00, 12'd7, 32'd0, 32'd5, 1'b0);
        do_cmd(3, 2'b11, 12'd7, 32'd0, 32'd5, 1'b0);

`ifdef GRID_CLAIM_EN
        do_cmd(1, 2'b10, 12'd14, 32'd3, 32'hFFFF_FFFF, 1'b1);
        do_cmd(0, 2'b00, 12'd14, 32'd0, 32'd3, 1'b0);
        do_cmd(2, 2'b10, 12'd14, 32'd8, 32'd3, 1'b0);
`else
        ram[14] = 32'd3;
        do_cmd(1, 2'b10, 12'd14, 32'd8, 32'd3, 1'b0);
        do_cmd(0, 2'b00, 12'd14, 32'd0, 32'd3, 1'b0);
`endif
        do_cmd(0, 2'b01, 12'd20, 32'h1234, 32'd0, 1'b0);
        do_cmd(3, 2'b00, 12'd20, 32'd0, 32'h1234, 1'b0);
        drain();

        // Round robin with everyone requesting continuously.
        do_reset();
        @(posedge clk); #1;
        for (int k = 0; k < NREQ; k++) drive(k, 2'b00, AW'(100 + k), '0);
        n = 0;
        for (int c = 0; c < 80 && n < 5; c++) begin
            @(negedge clk);
            if (|gnt) begin
                order[n] = oh_idx(gnt);
                sb.push_back('{idx: 8'(order[n]), ok: 1'b0,
                               data: 32'hA0 + DW'(order[n])});
                n++;
            end
        end
        @(posedge clk); #1;
        req = '0;
        chk("rr_count", 64'(n), 64'd5);
        for (int k = 0; k < 5; k++) chk("rr_order", 64'(order[k]), 64'(exp_order[k]));
        drain();
        wait_idle();

        // Simultaneous write and read of the same cell.
        do_reset();
        @(posedge clk); #1;
        drive(0, 2'b01, 12'd1, 32'd9);
        drive(1, 2'b00, 12'd1, 32'd0);
        sb.push_back('{idx: 8'd1, ok: 1'b0, data: 32'd9});
        wait_gnt(cnt);
        chk("b2b_first", 64'(gnt), 64'b0001);
        @(posedge clk); #1;
        req[0] = 1'b0;
        wait_gnt(cnt);
        chk("b2b_second", 64'(gnt), 64'b0010);
        @(posedge clk); #1;
        req[1] = 1'b0;
        drain();
        wait_idle();

        // Abort a read in RD; pointer must restart at 0.
        @(posedge clk); #1;
        drive(1, 2'b00, 12'd7, 32'd0);
        wait_gnt(cnt);
        chk("abort_gnt", 64'(gnt), 64'b0010);
        reset = 1'b1;
        req[1] = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rv", 64'(rvalid), 64'd0);
        chk("abort_rd", 64'(mem_read), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(2, 2'b00, 12'd102, 32'd0);
        drive(0, 2'b00, 12'd100, 32'd0);
        wait_gnt(cnt);
        chk("post_rst_first", 64'(gnt), 64'b0001);
        sb.push_back('{idx: 8'd0, ok: 1'b0, data: 32'hA0});
        @(posedge clk); #1;
        req[0] = 1'b0;
        wait_gnt(cnt);
        chk("post_rst_second", 64'(gnt), 64'b0100);
        sb.push_back('{idx: 8'd2, ok: 1'b0, data: 32'hA2});
        @(posedge clk); #1;
        req[2] = 1'b0;
        drain();
        wait_idle();
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/grid_port_arbiter.md
# grid_port_arbiter

Shares the single-port placement grid RAM (1-cycle registered read) between up to NREQ requesters: placement engine, evaluator, debug dump. Requesters issue read, write or atomic claim commands. A round-robin arbiter grants one command at a time, sequences the RAM control signals and returns read data tagged to the winner. It sits between the placement FSMs and the grid memoryRAM instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- ADDR_W, 12, grid address width
- DATA_W, 32, grid word width
- EMPTY, 32'hFFFFFFFF, encoding of an unoccupied cell (-1)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  NREQ  per-requester request; held until gnt seen
- op  in  2*NREQ  per-requester command, requester i at bits [2i+1:2i]; 00 read, 01 write, 10 claim, 11 treated as read
- addr  in  NREQ*ADDR_W  per-requester address, slice i
- wdata  in  NREQ*DATA_W  per-requester write data, slice i
- gnt  out  NREQ  one-hot, single-cycle grant pulse
- rvalid  out  NREQ  one-hot, single-cycle response pulse (read/claim only)
- rdata  out  DATA_W  response data, valid with rvalid
- claim_ok  out  1  claim succeeded, valid with rvalid
- busy  out  1  high whenever state != IDLE
- mem_read, mem_write  out  1  RAM strobes
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_read

## Operation
- All outputs registered. Reset values: gnt=0, rvalid=0, rdata=0, claim_ok=0, busy=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0. State IDLE, priority pointer 0.
- Arbitration, IDLE only: search req starting at pointer, ascending index with wrap. Winner w gets gnt[w]. Pointer becomes (w+1) mod NREQ. No arbitration outside IDLE; pending requests wait.
- Command fields of w are captured at the grant edge.
- States: IDLE, WR, RD, RESP, CHK, CWR.
  - IDLE -> WR (op 01): mem_write=1 with addr/wdata.
  - IDLE -> RD (op 00/11, or 10 when not claiming): mem_read=1.
  - IDLE -> CHK path (op 10 claim): mem_read=1.
  - WR -> IDLE.
  - RD -> RESP.
  - RESP -> IDLE: rdata<=mem_rdata, rvalid[w]=1, claim_ok=0.
  - Claim after the read cycle -> CHK. If mem_rdata==EMPTY: issue mem_write of wdata to the same address and go to CWR, with claim_ok=1. Otherwise claim_ok=0 and go to IDLE. In both cases rvalid[w]=1 and rdata=old cell value.
  - CWR -> IDLE.
- Write never produces rvalid.
- Requester rule: drop req (or present the next command) the cycle after gnt is seen. A req still high in IDLE is a new command.

## Timing
Cycle T is IDLE with req sampled high.
- Write: gnt and mem_write in T+1; IDLE in T+2.
- Read: gnt and mem_read in T+1; rvalid/rdata in T+3; IDLE in T+3, next grant earliest T+4.
- Claim success: gnt and mem_read in T+1; rvalid, claim_ok=1 and mem_write in T+3; IDLE in T+4.
- Claim fail: rvalid in T+3; IDLE in T+3.
- Simultaneous requests: only the winner is granted; the others are granted in later IDLE cycles in round-robin order. With all requesters continuously requesting, no requester waits more than NREQ-1 grants.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. A RAM strobe not yet driven is dropped. No rvalid is emitted for the aborted command.

## Configuration
- GRID_CLAIM_EN defined: op 10 performs the atomic test-and-set above (CHK/CWR states present).
- GRID_CLAIM_EN undefined: op 10 is executed as a plain read. claim_ok is tied 0. CHK/CWR are not built.

## Test plan
- Single read: requester 2 reads addr 7, RAM holds 5 -> gnt[2] at T+1, mem_read at T+1, rvalid[2]=1, rdata=5 at T+3.
- Round-robin: req=4'b1111 held after each gnt -> grant order 0,1,2,3,0; pointer wraps.
- Claim on empty cell (GRID_CLAIM_EN): addr 14 = FFFFFFFF, wdata 3 -> rvalid, claim_ok=1, rdata=FFFFFFFF, mem_write addr 14 data 3 at T+3; re-read returns 3.
- Claim on occupied cell: addr 14 = 3 -> claim_ok=0, rdata=3, no mem_write. Without GRID_CLAIM_EN, the same op returns rdata=3, claim_ok=0.
- Back-to-back: requester 0 writes addr 1=9 while requester 1 reads addr 1 -> write granted first, read returns 9.
- Reset asserted in RD state -> next cycle busy=0, no rvalid; the following request is granted normally, starting from requester 0.
